// File: rtl/wb_writer_if.sv
// wb_writer_if: bundles the ALU result, LSU handshake and register-file
// write port of wb_writer. The slave modport is the writer's view and the
// master modport is the view of whatever drives results into it.
// Defaults come from the `REG_ADDR_WIDTH / `REG_WIDTH macros when they are
// defined; otherwise they are 5 and 32.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

interface wb_writer_if #(
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int unsigned REG_WIDTH      = `REG_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 4
) ();

  localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  // ALU result source (single cycle, highest normal priority)
  logic                      alu_valid;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [REG_WIDTH-1:0]      alu_data;
  logic                      alu_stall;

  // LSU result source (valid/ready handshake into the buffer)
  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [REG_ADDR_WIDTH-1:0] lsu_rd;
  logic [REG_WIDTH-1:0]      lsu_data;

  // Register file write port
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] addr_rd;
  logic [REG_WIDTH-1:0]      data_rd;

  // Buffer occupancy
  logic [CNT_WIDTH-1:0]      fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output wr_en, addr_rd, data_rd,
    output fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  wr_en, addr_rd, data_rd,
    input  fifo_count
  );

endinterface

// File: rtl/wb_writer.sv
// wb_writer: register file writeback initiator.
// ALU results are written the cycle after they are offered and have priority.
// LSU results are buffered in a FIFO and written when the ALU leaves a gap.
// A starvation counter forces the FIFO head through (stalling the ALU for one
// cycle) once the head has been blocked STARVE_LIMIT consecutive cycles.
// Writes to register 0 are consumed but never issued.
// Optional feature macro: WB_BYPASS_EN -- when the FIFO is empty and no ALU
// write is selected, an accepted LSU result is written directly (latency 1).

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module wb_writer #(
  parameter int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int unsigned REG_WIDTH      = `REG_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input logic         clk,
  input logic         reset,
  wb_writer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  // Which source drives the register file write this cycle
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_FORCE,
    SEL_ALU,
    SEL_FIFO,
    SEL_BYPASS
  } sel_e;

  // FIFO storage and control
  logic [REG_ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [REG_WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic [STV_W-1:0]          starve_q;

  // Registered write port
  logic                      wr_en_q;
  logic [REG_ADDR_WIDTH-1:0] addr_rd_q;
  logic [REG_WIDTH-1:0]      data_rd_q;

  // Combinational decisions
  sel_e                      sel;
  logic                      fifo_empty;
  logic                      lsu_ready;
  logic                      lsu_xfer;
  logic                      alu_write;
  logic                      force_pop;
  logic                      push;
  logic                      pop;
  logic [REG_ADDR_WIDTH-1:0] wr_rd_d;
  logic [REG_WIDTH-1:0]      wr_data_d;

  assign fifo_empty = (count_q == '0);
  assign lsu_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign lsu_xfer   = bus.lsu_valid & lsu_ready;
  assign alu_write  = bus.alu_valid & (bus.alu_rd != '0);
  assign force_pop  = (starve_q == STV_W'(STARVE_LIMIT)) & ~fifo_empty;

  assign bus.lsu_ready  = lsu_ready;
  assign bus.alu_stall  = force_pop & bus.alu_valid;
  assign bus.wr_en      = wr_en_q;
  assign bus.addr_rd    = addr_rd_q;
  assign bus.data_rd    = data_rd_q;
  assign bus.fifo_count = count_q;

  // Priority write select: forced head, ALU, buffered head, then optional bypass
  always_comb begin
    sel = SEL_NONE;
    if (force_pop) begin
      sel = SEL_FORCE;
    end else if (alu_write) begin
      sel = SEL_ALU;
    end else if (!fifo_empty) begin
      sel = SEL_FIFO;
    end
`ifdef WB_BYPASS_EN
    else if (lsu_xfer && (bus.lsu_rd != '0)) begin
      sel = SEL_BYPASS;
    end
`endif
  end

  // Buffer push/pop and the write data mux for the selected source
  always_comb begin
    push      = lsu_xfer & (bus.lsu_rd != '0) & (sel != SEL_BYPASS);
    pop       = (sel == SEL_FORCE) | (sel == SEL_FIFO);
    wr_rd_d   = addr_rd_q;
    wr_data_d = data_rd_q;
    unique case (sel)
      SEL_ALU: begin
        wr_rd_d   = bus.alu_rd;
        wr_data_d = bus.alu_data;
      end
      SEL_FORCE, SEL_FIFO: begin
        wr_rd_d   = fifo_rd_q[rd_ptr_q];
        wr_data_d = fifo_data_q[rd_ptr_q];
      end
      SEL_BYPASS: begin
        wr_rd_d   = bus.lsu_rd;
        wr_data_d = bus.lsu_data;
      end
      default: begin
        wr_rd_d   = addr_rd_q;
        wr_data_d = data_rd_q;
      end
    endcase
  end

  // FIFO entry storage; contents need no reset since count gates their use
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
      fifo_data_q[wr_ptr_q] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Starvation counter: counts cycles the head loses to the ALU, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (pop || fifo_empty) begin
      starve_q <= '0;
    end else if ((sel == SEL_ALU) && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + STV_W'(1);
    end
  end

  // Registered write port; address/data hold when nothing is selected
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      addr_rd_q <= '0;
      data_rd_q <= '0;
    end else begin
      wr_en_q <= (sel != SEL_NONE);
      if (sel != SEL_NONE) begin
        addr_rd_q <= wr_rd_d;
        data_rd_q <= wr_data_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed stimulus for wb_writer with a write scoreboard.
// The stimulus process pushes each expected register write into a queue;
// a monitor pops and compares on every cycle the DUT asserts wr_en.
// Occupancy, ready, stall and latency are checked directly by the stimulus.

module tb_wb_writer;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

`ifdef WB_BYPASS_EN
  localparam int unsigned BYP = 1;
`else
  localparam int unsigned BYP = 0;
`endif

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic reset;
  wr_t  exp_q [$];
  int   n_cmp;
  int   n_bad;

  wb_writer_if #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  wb_writer #(
    .REG_ADDR_WIDTH(AW),
    .REG_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wr_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every asserted write must match the next expected write in order
  always @(negedge clk) begin
    if (bus.wr_en !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write",
                 bus.addr_rd, bus.data_rd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({bus.addr_rd, bus.data_rd} !== {e.rd, e.data}) begin
          n_bad++;
          $display("FAIL wb_write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                   bus.addr_rd, bus.data_rd, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive_alu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    tick();
    tick();

    // Reset state
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_addr", bus.addr_rd, 0);
    check("rst_data", bus.data_rd, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.lsu_ready, 1);
    check("rst_stall", bus.alu_stall, 0);
    reset = 1'b0;
    tick();

    // ALU path: 1-cycle latency, then idle with address held
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    drive_alu(1'b0, '0, '0);
    check("alu_wr_en", bus.wr_en, 1);
    check("alu_addr", bus.addr_rd, 5);
    check("alu_data", bus.data_rd, 32'hDEADBEEF);
    tick();
    check("alu_idle_wr_en", bus.wr_en, 0);
    check("alu_idle_hold", bus.addr_rd, 5);

    // x0 discard on both sources
    drive_alu(1'b1, 5'd0, 32'h12345678);
    tick();
    drive_alu(1'b0, '0, '0);
    check("x0_alu_wr_en", bus.wr_en, 0);
    drive_lsu(1'b1, 5'd0, 32'h99);
    #1;
    check("x0_lsu_ready", bus.lsu_ready, 1);
    tick();
    drive_lsu(1'b0, '0, '0);
    check("x0_count", bus.fifo_count, 0);
    check("x0_lsu_wr_en0", bus.wr_en, 0);
    tick();
    check("x0_lsu_wr_en1", bus.wr_en, 0);
    check("x0_count_after", bus.fifo_count, 0);

    // LSU latency (bypass: 1 cycle, otherwise 2 through the FIFO)
    drive_lsu(1'b1, 5'd7, 32'h55);
    expect_wr(5'd7, 32'h55);
    tick();
    drive_lsu(1'b0, '0, '0);
`ifdef WB_BYPASS_EN
    check("byp_wr_en_n1", bus.wr_en, 1);
    check("byp_addr_n1", bus.addr_rd, 7);
    check("byp_count", bus.fifo_count, 0);
`else
    check("lsu_wr_en_n1", bus.wr_en, 0);
    check("lsu_count_n1", bus.fifo_count, 1);
    tick();
    check("lsu_wr_en_n2", bus.wr_en, 1);
    check("lsu_addr_n2", bus.addr_rd, 7);
    check("lsu_data_n2", bus.data_rd, 32'h55);
    check("lsu_count_n2", bus.fifo_count, 0);
`endif
    tick();

    // Simultaneous push and pop keeps occupancy unchanged
    drive_lsu(1'b1, 5'd20, 32'h2020);
    expect_wr(5'd20, 32'h2020);
    tick();
    check("pp_count0", bus.fifo_count, (BYP != 0) ? 0 : 1);
    drive_lsu(1'b1, 5'd21, 32'h2121);
    expect_wr(5'd21, 32'h2121);
    tick();
    drive_lsu(1'b0, '0, '0);
    check("pp_count1", bus.fifo_count, (BYP != 0) ? 0 : 1);
    tick();
    tick();
    check("pp_count_drained", bus.fifo_count, 0);

    // Fill the FIFO behind a continuously valid ALU
    drive_alu(1'b1, 5'd1, 32'h11111111);
    for (int i = 0; i < 4; i++) begin
      drive_lsu(1'b1, AW'(10 + i), DW'(32'hA0 + i));
      expect_wr(5'd1, 32'h11111111);
      tick();
      check("full_count", bus.fifo_count, i + 1);
    end

    // Starvation: each head forced after 3 blocked cycles, in order
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive_lsu(1'b1, 5'd14, 32'hEE);
      else        drive_lsu(1'b0, '0, '0);
      #1;
      check("starve_stall", bus.alu_stall, 1);
      if (k == 0) check("full_ready", bus.lsu_ready, 0);
      expect_wr(AW'(10 + k), DW'(32'hA0 + k));
      tick();
      drive_lsu(1'b0, '0, '0);
      check("starve_count", bus.fifo_count, 3 - k);
      if (k < 3) begin
        for (int j = 0; j < 3; j++) begin
          #1;
          check("starve_no_stall", bus.alu_stall, 0);
          expect_wr(5'd1, 32'h11111111);
          tick();
        end
      end
    end
    expect_wr(5'd1, 32'h11111111);
    tick();
    drive_alu(1'b0, '0, '0);
    tick();
    tick();

    // Reset with two entries queued and ALU valid
    drive_alu(1'b1, 5'd2, 32'h22222222);
    drive_lsu(1'b1, 5'd30, 32'h30);
    expect_wr(5'd2, 32'h22222222);
    tick();
    drive_lsu(1'b1, 5'd31, 32'h31);
    expect_wr(5'd2, 32'h22222222);
    tick();
    drive_lsu(1'b0, '0, '0);
    check("mid_count", bus.fifo_count, 2);
    reset = 1'b1;
    tick();
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_count", bus.fifo_count, 0);
    check("mid_rst_ready", bus.lsu_ready, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", bus.alu_stall, 0);
    drive_alu(1'b0, '0, '0);
    repeat (6) tick();
    check("post_rst_count", bus.fifo_count, 0);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback initiator for the register file write port. Drives wr_en/addr_rd/data_rd from two result sources.
- ALU results are single-cycle and have priority.
- LSU results arrive with a valid/ready handshake and are buffered in a FIFO.
- A starvation counter forces the FIFO head through, stalling the ALU for one cycle, so LSU writes always complete.

Parameters:
- REG_ADDR_WIDTH, `REG_ADDR_WIDTH (5): register index width.
- REG_WIDTH, `REG_WIDTH (32): data width.
- FIFO_DEPTH, 4: LSU buffer entries; must be a power of 2 and at least 2.
- STARVE_LIMIT, 3: consecutive cycles a non-empty FIFO head may be blocked before it is forced.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid this cycle.
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register.
- alu_data  in  REG_WIDTH  ALU result.
- alu_stall  out  1  ALU result not consumed this cycle; upstream holds alu_* stable.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept an LSU result.
- lsu_rd  in  REG_ADDR_WIDTH  LSU destination register.
- lsu_data  in  REG_WIDTH  LSU result.
- wr_en  out  1  register file write enable (registered).
- addr_rd  out  REG_ADDR_WIDTH  register file write address (registered).
- data_rd  out  REG_WIDTH  register file write data (registered).
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, sampled at a rising edge of clk:
  - wr_en=0, addr_rd=0, data_rd=0, alu_stall=0.
  - FIFO emptied, fifo_count=0, starve_cnt=0.
  - Reset mid-operation discards all queued entries, and no write issues in the following cycle.
- lsu_ready = (fifo_count < FIFO_DEPTH). This is combinational from registered count, with no full-cycle pop bypass.
- LSU transfer:
  - A transfer occurs when lsu_valid & lsu_ready.
  - If lsu_rd==0, the result is accepted and discarded (not enqueued).
- force = (starve_cnt == STARVE_LIMIT) & (fifo_count != 0). alu_stall = force & alu_valid.
- Write select each cycle, in priority order:
  1. force: pop FIFO head and write it. The ALU result is not consumed.
  2. alu_valid & alu_rd!=0: write the ALU result. alu_valid with alu_rd==0 is consumed with no write.
  3. FIFO non-empty: pop head and write it.
  4. Otherwise: no write.
- Outputs register the selected write, so wr_en/addr_rd/data_rd are valid in the cycle after selection.
  - ALU latency: 1 cycle.
  - LSU minimum latency: 2 cycles (enqueue cycle N, pop N+1, wr_en at N+2).
  - When nothing is selected, wr_en=0 and addr_rd/data_rd hold their previous values.
- starve_cnt:
  - Clears to 0 on any pop or when the FIFO is empty.
  - Otherwise increments while the head is blocked (case 2 selected with FIFO non-empty).
  - Saturates at STARVE_LIMIT.
- Simultaneous push and pop in the same cycle: count unchanged. Push is allowed only if lsu_ready was high, so a full FIFO never overflows.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Order is strict FIFO.
- wr_en is never asserted with addr_rd==0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- With the macro defined: when the FIFO is empty, no ALU write is selected, and an LSU transfer with lsu_rd!=0 occurs, the LSU result is written directly without enqueue. LSU latency becomes 1 cycle and fifo_count stays 0.
- Without the macro: every LSU result passes through the FIFO (minimum latency 2).

Test Plan:
- Reset:
  - Stimulus: assert reset while 2 LSU entries are queued, alu_valid=1.
  - Response: next cycle wr_en=0, fifo_count=0, lsu_ready=1, alu_stall=0, with no later write of the queued entries.
- ALU path:
  - Stimulus: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N.
  - Response: wr_en=1, addr_rd=5, data_rd=0xDEADBEEF at N+1; wr_en=0 at N+2 if idle.
- x0 discard:
  - Stimulus: alu_rd=0 at cycle N; LSU transfer with lsu_rd=0 at cycle N+1.
  - Response: wr_en stays 0 throughout and fifo_count stays 0.
- FIFO full:
  - Stimulus: hold alu_valid=1 (rd=1) and push 4 LSU results, rd=10..13.
  - Response: lsu_ready=0 when fifo_count=4, and a 5th offer is not accepted.
- Starvation:
  - Stimulus: continue holding alu_valid=1 from the FIFO-full scenario.
  - Response: after 3 blocked cycles, alu_stall=1 for one cycle and rd=10 is written next cycle. This repeats every 4 cycles, and rd=10..13 are written in order.
- Bypass:
  - Stimulus: with WB_BYPASS_EN, FIFO empty and no ALU, LSU transfers rd=7, data=0x55 at cycle N.
  - Response: write at N+1 and fifo_count=0. Without the macro, the write occurs at N+2.
